// File: rtl/ac_match_engine.sv
// ac_match_engine: streaming Aho-Corasick matcher.
// Goto, failure and output tables are internal register arrays loaded through
// a write port. One character is accepted per cycle over valid/ready. Failure
// links are walked one hop per cycle while the input is stalled.
// Optional build macro: AC_MATCH_COUNT_EN adds saturating MATCH_CNT / FAIL_CNT.
module ac_match_engine #(
  parameter int STATE_W = 8,
  parameter int CHAR_W  = 4,
  parameter int POS_W   = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic                       CLR,
  input  logic                       WR_EN,
  input  logic [1:0]                 WR_SEL,
  input  logic [STATE_W+CHAR_W-1:0]  WR_ADDR,
  input  logic [STATE_W-1:0]         WR_DATA,
  input  logic [CHAR_W-1:0]          CHAR_IN,
  input  logic                       CHAR_VALID,
  output logic                       CHAR_READY,
  output logic                       MATCH_VALID,
  output logic [STATE_W-1:0]         MATCH_STATE,
  output logic [POS_W-1:0]           MATCH_POS,
  output logic [STATE_W-1:0]         CUR_STATE
`ifdef AC_MATCH_COUNT_EN
  ,
  output logic [31:0]                MATCH_CNT,
  output logic [31:0]                FAIL_CNT
`endif
);

  localparam int ADDR_W      = STATE_W + CHAR_W;
  localparam int GOTO_DEPTH  = 1 << ADDR_W;
  localparam int STATE_DEPTH = 1 << STATE_W;

  typedef enum logic [0:0] {
    ACCEPT    = 1'b0,
    FAIL_WALK = 1'b1
  } fsm_t;

  // Tables
  logic [STATE_W-1:0]     goto_data [GOTO_DEPTH];
  logic [GOTO_DEPTH-1:0]  goto_valid;
  logic [STATE_W-1:0]     fail_tab  [STATE_DEPTH];
  logic [STATE_DEPTH-1:0] out_flag;

  // Engine state
  fsm_t               fsm_reg, fsm_next;
  logic [STATE_W-1:0] cur_state_reg, cur_state_next;
  logic [POS_W-1:0]   pos_reg, pos_next;
  logic [CHAR_W-1:0]  char_reg, char_next;
  logic               match_valid_reg, match_valid_next;
  logic [STATE_W-1:0] match_state_reg, match_state_next;
  logic [POS_W-1:0]   match_pos_reg, match_pos_next;

  // Lookup path
  logic               tbl_wr;
  logic [CHAR_W-1:0]  lookup_char;
  logic [ADDR_W-1:0]  lookup_addr;
  logic               entry_valid;
  logic [STATE_W-1:0] entry_state;
  logic               entry_flag;
  logic               step;
  logic               fail_hop;

  // Writes are only honoured while the engine sits in ACCEPT, so a walk never
  // sees its tables change underneath it.
  assign tbl_wr = WR_EN & (fsm_reg == ACCEPT);

  // Goto next-state data has no reset; only the valid bits are cleared.
  always_ff @(posedge CLK) begin
    if (tbl_wr && WR_SEL == 2'd0)
      goto_data[WR_ADDR] <= WR_DATA;
  end

  // Goto valid bits: set on a goto write, cleared by invalidate or reset.
  always_ff @(posedge CLK) begin
    if (RST)
      goto_valid <= '0;
    else if (tbl_wr && WR_SEL == 2'd0)
      goto_valid[WR_ADDR] <= 1'b1;
    else if (tbl_wr && WR_SEL == 2'd3)
      goto_valid[WR_ADDR] <= 1'b0;
  end

  // Failure links: software must load them, no reset.
  always_ff @(posedge CLK) begin
    if (tbl_wr && WR_SEL == 2'd1)
      fail_tab[WR_ADDR[STATE_W-1:0]] <= WR_DATA;
  end

  // Output flags: bit 0 of the write data, cleared on reset.
  always_ff @(posedge CLK) begin
    if (RST)
      out_flag <= '0;
    else if (tbl_wr && WR_SEL == 2'd2)
      out_flag[WR_ADDR[STATE_W-1:0]] <= WR_DATA[0];
  end

  assign CHAR_READY = EN & ~WR_EN & (fsm_reg == ACCEPT) & ~CLR;

  // In ACCEPT the live character is looked up; in FAIL_WALK the latched one.
  assign lookup_char = (fsm_reg == ACCEPT) ? CHAR_IN : char_reg;
  assign lookup_addr = {cur_state_reg, lookup_char};
  assign entry_valid = goto_valid[lookup_addr];
  assign entry_state = goto_data[lookup_addr];
  assign entry_flag  = out_flag[entry_state];

  // Gating by EN and CLR is applied in the state register.
  assign step = (fsm_reg == ACCEPT) ? (CHAR_VALID & CHAR_READY) : 1'b1;

  // Next-state: hit, miss at root, or one failure hop.
  always_comb begin
    fsm_next         = fsm_reg;
    cur_state_next   = cur_state_reg;
    pos_next         = pos_reg;
    char_next        = char_reg;
    match_valid_next = 1'b0;
    match_state_next = match_state_reg;
    match_pos_next   = match_pos_reg;
    fail_hop         = 1'b0;
    if (step) begin
      if (entry_valid) begin
        cur_state_next = entry_state;
        fsm_next       = ACCEPT;
        pos_next       = pos_reg + POS_W'(1);
        if (entry_flag) begin
          match_valid_next = 1'b1;
          match_state_next = entry_state;
          match_pos_next   = pos_reg;
        end
      end else if (cur_state_reg == '0) begin
        fsm_next = ACCEPT;
        pos_next = pos_reg + POS_W'(1);
      end else begin
        cur_state_next = fail_tab[cur_state_reg];
        char_next      = lookup_char;
        fsm_next       = FAIL_WALK;
        fail_hop       = 1'b1;
      end
    end
  end

  // State register: RST, then CLR, then EN-qualified update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_reg         <= ACCEPT;
      cur_state_reg   <= '0;
      pos_reg         <= '0;
      char_reg        <= '0;
      match_valid_reg <= 1'b0;
      match_state_reg <= '0;
      match_pos_reg   <= '0;
    end else if (CLR) begin
      fsm_reg         <= ACCEPT;
      cur_state_reg   <= '0;
      pos_reg         <= '0;
      char_reg        <= '0;
      match_valid_reg <= 1'b0;
    end else if (EN) begin
      fsm_reg         <= fsm_next;
      cur_state_reg   <= cur_state_next;
      pos_reg         <= pos_next;
      char_reg        <= char_next;
      match_valid_reg <= match_valid_next;
      match_state_reg <= match_state_next;
      match_pos_reg   <= match_pos_next;
    end else begin
      match_valid_reg <= 1'b0;
    end
  end

  // A pulse is never visible while the engine is disabled or being cleared.
  assign MATCH_VALID = match_valid_reg & EN & ~CLR;
  assign MATCH_STATE = match_state_reg;
  assign MATCH_POS   = match_pos_reg;
  assign CUR_STATE   = cur_state_reg;

`ifdef AC_MATCH_COUNT_EN
  logic [31:0] match_cnt_reg;
  logic [31:0] fail_cnt_reg;

  // Saturating event counters, cleared by RST or CLR.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      match_cnt_reg <= '0;
      fail_cnt_reg  <= '0;
    end else begin
      if (MATCH_VALID && match_cnt_reg != 32'hFFFF_FFFF)
        match_cnt_reg <= match_cnt_reg + 32'd1;
      if (EN && fail_hop && fail_cnt_reg != 32'hFFFF_FFFF)
        fail_cnt_reg <= fail_cnt_reg + 32'd1;
    end
  end

  assign MATCH_CNT = match_cnt_reg;
  assign FAIL_CNT  = fail_cnt_reg;
`endif

endmodule

// File: tb/tb_ac_match_engine.sv
// Directed bench for ac_match_engine using the {he, she, his, hers} dictionary.
// Inputs change on the falling edge; outputs are sampled mid-cycle.
module tb_ac_match_engine;

  logic        CLK = 1'b0;
  logic        RST, EN, CLR, WR_EN;
  logic [1:0]  WR_SEL;
  logic [11:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [3:0]  CHAR_IN;
  logic        CHAR_VALID, CHAR_READY, MATCH_VALID;
  logic [7:0]  MATCH_STATE, CUR_STATE;
  logic [15:0] MATCH_POS;
`ifdef AC_MATCH_COUNT_EN
  logic [31:0] MATCH_CNT, FAIL_CNT;
`endif

  always #5 CLK = ~CLK;

  ac_match_engine dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR),
    .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CHAR_IN(CHAR_IN), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .MATCH_VALID(MATCH_VALID), .MATCH_STATE(MATCH_STATE), .MATCH_POS(MATCH_POS),
    .CUR_STATE(CUR_STATE)
`ifdef AC_MATCH_COUNT_EN
    , .MATCH_CNT(MATCH_CNT), .FAIL_CNT(FAIL_CNT)
`endif
  );

  int total = 0;
  int bad   = 0;
  int stalls = 0;
  int base;
  logic [7:0]  mq_state[$];
  logic [15:0] mq_pos[$];

  // Match recorder: one line per reported match.
  always @(posedge CLK) begin
    #1;
    if (MATCH_VALID === 1'b1) begin
      mq_state.push_back(MATCH_STATE);
      mq_pos.push_back(MATCH_POS);
      $display("match state=%0d pos=%0d", MATCH_STATE, MATCH_POS);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_match(input string tag, input int idx, input int st, input int pos);
    if (mq_state.size() > idx) begin
      chk({tag, "_state"}, 32'(mq_state[idx]), 32'(st));
      chk({tag, "_pos"}, 32'(mq_pos[idx]), 32'(pos));
    end else begin
      total++;
      bad++;
      $error("FAIL %s missing match observed_count=%0d expected_index=%0d", tag, mq_state.size(), idx);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [11:0] addr, input logic [7:0] data);
    WR_EN = 1'b1; WR_SEL = sel; WR_ADDR = addr; WR_DATA = data;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  // Present a character and hold it until accepted (bounded).
  task automatic send(input logic [3:0] c);
    int n;
    n = 0;
    CHAR_IN = c;
    CHAR_VALID = 1'b1;
    #1;
    while (CHAR_READY !== 1'b1 && n < 50) begin
      stalls++;
      @(negedge CLK);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout char=%0d observed_ready=%b expected_ready=1", c, CHAR_READY);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    CHAR_VALID = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_clr();
    CHAR_VALID = 1'b0;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic load_tables();
    int gs[9] = '{0, 1, 0, 3, 4, 1, 6, 2, 8};
    int gc[9] = '{1, 2, 3, 1, 2, 4, 3, 5, 3};
    int gn[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int fv[10] = '{0, 0, 0, 0, 1, 2, 0, 3, 0, 3};
    int fl[4] = '{2, 5, 7, 9};
    for (int k = 0; k < 9; k++)
      wr(2'd0, {gs[k][7:0], gc[k][3:0]}, gn[k][7:0]);
    for (int k = 0; k < 10; k++)
      wr(2'd1, 12'(k), fv[k][7:0]);
    for (int k = 0; k < 4; k++)
      wr(2'd2, 12'(fl[k]), 8'd1);
  endtask

  // "ushers": u=6 s=3 h=1 e=2 r=5 s=3
  task automatic send_usher();
    send(4'd6); send(4'd3); send(4'd1); send(4'd2); send(4'd5);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; CLR = 1'b0; WR_EN = 1'b0;
    WR_SEL = 2'd0; WR_ADDR = '0; WR_DATA = '0;
    CHAR_IN = '0; CHAR_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_cur_state", 32'(CUR_STATE), 32'd0);
    chk("rst_match_valid", 32'(MATCH_VALID), 32'd0);
    chk("rst_match_state", 32'(MATCH_STATE), 32'd0);
    chk("rst_match_pos", 32'(MATCH_POS), 32'd0);
    chk("rst_ready", 32'(CHAR_READY), 32'd1);
    @(negedge CLK);

    // A table write blocks acceptance in that cycle.
    WR_EN = 1'b1; WR_SEL = 2'd1; WR_ADDR = 12'd0; WR_DATA = 8'd0;
    #1;
    chk("wr_blocks_ready", 32'(CHAR_READY), 32'd0);
    @(negedge CLK);
    WR_EN = 1'b0;
    load_tables();

    // Stream "ushers" back to back.
    base = mq_state.size();
    stalls = 0;
    send_usher();
    send(4'd3);
    idle(3);
    chk("ushers_count", 32'(mq_state.size()), 32'(base + 2));
    chk_match("ushers_m0", base, 5, 3);
    chk_match("ushers_m1", base + 1, 9, 5);
    chk("ushers_stalls", 32'(stalls), 32'd1);
    chk("ushers_final_state", 32'(CUR_STATE), 32'd9);
`ifdef AC_MATCH_COUNT_EN
    chk("ushers_match_cnt", MATCH_CNT, 32'd2);
    chk("ushers_fail_cnt", FAIL_CNT, 32'd1);
`endif

    // Stream "hhis": second 'h' falls back to root and re-enters state 1.
    do_clr();
`ifdef AC_MATCH_COUNT_EN
    chk("clr_match_cnt", MATCH_CNT, 32'd0);
    chk("clr_fail_cnt", FAIL_CNT, 32'd0);
`endif
    base = mq_state.size();
    send(4'd1); send(4'd1);
    idle(2);
    chk("hhis_state_after_hh", 32'(CUR_STATE), 32'd1);
    send(4'd4); send(4'd3);
    idle(3);
    chk("hhis_count", 32'(mq_state.size()), 32'(base + 1));
    chk_match("hhis_m0", base, 7, 3);

    // "ushers" with EN low for 3 cycles inside the walk caused by 'r'.
    do_clr();
    base = mq_state.size();
    send_usher();
    EN = 1'b0;
    CHAR_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("freeze_state", 32'(CUR_STATE), 32'd2);
      chk("freeze_ready", 32'(CHAR_READY), 32'd0);
    end
    chk("freeze_match_valid", 32'(MATCH_VALID), 32'd0);
    EN = 1'b1;
    send(4'd3);
    idle(3);
    chk("freeze_count", 32'(mq_state.size()), 32'(base + 2));
    chk_match("freeze_m0", base, 5, 3);
    chk_match("freeze_m1", base + 1, 9, 5);
    chk("freeze_final_state", 32'(CUR_STATE), 32'd9);

    // Invalidate goto(2,r): "her" walks from 2 to root and stops there.
    do_clr();
    wr(2'd3, {8'd2, 4'd5}, 8'd0);
    base = mq_state.size();
    send(4'd1); send(4'd2); send(4'd5);
    idle(3);
    chk("inval_count", 32'(mq_state.size()), 32'(base + 1));
    chk_match("inval_m0", base, 2, 1);
    chk("inval_final_state", 32'(CUR_STATE), 32'd0);
    wr(2'd0, {8'd2, 4'd5}, 8'd8);

    // CLR after "sh": back to root, then "he" from position 0.
    do_clr();
    send(4'd3); send(4'd1);
    chk("pre_clr_state", 32'(CUR_STATE), 32'd4);
    CHAR_VALID = 1'b0;
    CLR = 1'b1;
    #1;
    chk("clr_match_valid_live", 32'(MATCH_VALID), 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_state", 32'(CUR_STATE), 32'd0);
    chk("clr_match_valid", 32'(MATCH_VALID), 32'd0);
    base = mq_state.size();
    send(4'd1); send(4'd2);
    idle(3);
    chk("clr_he_count", 32'(mq_state.size()), 32'(base + 1));
    chk_match("clr_he_m0", base, 2, 1);

    // RST after "sh": tables invalidated, so "he" no longer matches.
    send(4'd3); send(4'd1);
    CHAR_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst2_state", 32'(CUR_STATE), 32'd0);
    chk("rst2_match_valid", 32'(MATCH_VALID), 32'd0);
    chk("rst2_match_state", 32'(MATCH_STATE), 32'd0);
    base = mq_state.size();
    send(4'd1); send(4'd2);
    idle(3);
    chk("rst2_he_count", 32'(mq_state.size()), 32'(base));
    chk("rst2_final_state", 32'(CUR_STATE), 32'd0);
    chk("rst2_ready", 32'(CHAR_READY), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
